// File: rtl/ntt_bram_pkg.sv
// Shared types and default parameter values for the BRAM-to-NTT streaming controller.
package ntt_bram_pkg;

    localparam int N_DEF          = 64;
    localparam int DATA_W_DEF     = 64;
    localparam int ADDR_W_DEF     = 13;
    localparam int BYTE_SHIFT_DEF = 2;
    localparam int RD_LAT_DEF     = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_STORE   = 3'd5,
        ST_FINISH  = 3'd6
    } ntt_bram_state_t;

endpackage

// File: rtl/ntt_bram_ctrl_if.sv
// Single-port BRAM bus between the controller (master) and the memory (slave).
interface ntt_bram_ctrl_if
    import ntt_bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              bram_clk;
    logic              bram_rst;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport master (
        output bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_din,
        output bram_dout
    );
endinterface

// File: rtl/ntt_bram_rdpipe.sv
// Delay line that follows each read request through the BRAM latency and
// raises a capture strobe, with the word index, in the cycle its data is valid.
module ntt_bram_rdpipe
    import ntt_bram_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_idx
);
    logic [RD_LAT-1:0] vld_r;
    logic [IDX_W-1:0]  idx_r [RD_LAT];

    // Shift valid and index one stage per cycle; stage RD_LAT-1 lines up with returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= req_valid;
            idx_r[0] <= req_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                idx_r[i] <= idx_r[i-1];
            end
        end
    end

    assign cap_valid = vld_r[RD_LAT-1];
    assign cap_idx   = idx_r[RD_LAT-1];
endmodule

// File: rtl/ntt_bram_ctrl.sv
// BRAM-to-NTT streaming controller: burst-reads N words into the core input
// buffer, launches the core, snapshots its result and burst-writes it back.
module ntt_bram_ctrl
    import ntt_bram_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BYTE_SHIFT = BYTE_SHIFT_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    localparam int WADDR_W   = ADDR_W - BYTE_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WADDR_W-1:0]  src_base,
    input  logic [WADDR_W-1:0]  dst_base,
    output logic                busy,
    output logic                done,
    ntt_bram_ctrl_if.master     bram,
    output logic [N*DATA_W-1:0] core_x,
    output logic                core_start,
    input  logic                core_done,
    input  logic [N*DATA_W-1:0] core_y
);
    // Counter covers both word index (N-1) and drain length (up to 4).
    localparam int CNT_W = (N > 4) ? $clog2(N) : 2;

    ntt_bram_state_t    state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n, cnt_inc_s;
    logic [WADDR_W-1:0] src_r, src_n, dst_r, dst_n;
    logic [ADDR_W-1:0]  addr_r, addr_n;
    logic [DATA_W-1:0]  din_r, din_n;
    logic               en_r, we_r, busy_r, done_r, core_start_r;
    logic [N*DATA_W-1:0] x_r, y_r;
    logic               snap_s;
    logic               cap_valid_s;
    logic [CNT_W-1:0]   cap_idx_s;

    function automatic logic [ADDR_W-1:0] to_byte(input logic [WADDR_W-1:0] word);
        return ADDR_W'(word) << BYTE_SHIFT;
    endfunction

    // Next state and the port request for the coming cycle.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        src_n     = src_r;
        dst_n     = dst_r;
        addr_n    = '0;
        din_n     = '0;
        snap_s    = 1'b0;
        cnt_inc_s = cnt_r + CNT_W'(1);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    src_n   = src_base;
                    dst_n   = dst_base;
                    cnt_n   = '0;
                    addr_n  = to_byte(src_base);
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_r == CNT_W'(N - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_DRAIN;
                end else begin
                    cnt_n  = cnt_inc_s;
                    addr_n = to_byte(src_r + WADDR_W'(cnt_inc_s));
                end
            end
            ST_DRAIN: begin
                if (cnt_r == CNT_W'(RD_LAT - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_COMPUTE;
                end else begin
                    cnt_n = cnt_inc_s;
                end
            end
            ST_COMPUTE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    snap_s  = 1'b1;
                    cnt_n   = '0;
                    addr_n  = to_byte(dst_r);
                    din_n   = core_y[0 +: DATA_W];
                    state_n = ST_STORE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (cnt_r == CNT_W'(N - 1)) begin
                    state_n = ST_FINISH;
                end else begin
                    cnt_n  = cnt_inc_s;
                    addr_n = to_byte(dst_r + WADDR_W'(cnt_inc_s));
                    din_n  = y_r[int'(cnt_inc_s)*DATA_W +: DATA_W];
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, bases and registered port/handshake outputs for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            src_r        <= '0;
            dst_r        <= '0;
            addr_r       <= '0;
            din_r        <= '0;
            en_r         <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            core_start_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            src_r        <= src_n;
            dst_r        <= dst_n;
            addr_r       <= addr_n;
            din_r        <= din_n;
            en_r         <= (state_n == ST_LOAD) || (state_n == ST_STORE);
            we_r         <= (state_n == ST_STORE);
            busy_r       <= (state_n != ST_IDLE);
            done_r       <= (state_n == ST_FINISH);
            core_start_r <= (state_n == ST_COMPUTE);
        end
    end

    ntt_bram_rdpipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (CNT_W)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .req_valid (en_r & ~we_r),
        .req_idx   (cnt_r),
        .cap_valid (cap_valid_s),
        .cap_idx   (cap_idx_s)
    );

    // Load buffer fills from returned read data; result buffer takes one snapshot per job.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else begin
            if (cap_valid_s) begin
                x_r[int'(cap_idx_s)*DATA_W +: DATA_W] <= bram.bram_dout;
            end
            if (snap_s) begin
                y_r <= core_y;
            end
        end
    end

    assign bram.bram_clk  = clk;
    assign bram.bram_rst  = rst;
    assign bram.bram_en   = en_r;
    assign bram.bram_we   = we_r;
    assign bram.bram_addr = addr_r;
    assign bram.bram_din  = din_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign core_start     = core_start_r;
    assign core_x         = x_r;
endmodule

// File: tb/tb_ntt_bram_ctrl.sv
// Bench for ntt_bram_ctrl: two instances (read latency 1 and 2) run the same
// randomized jobs against behavioural BRAM and core models.
module tb_ntt_bram_ctrl;
    import ntt_bram_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int BS    = 2;
    localparam int WW    = AW - BS;
    localparam int DEPTH = 1 << WW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_all;
    logic [1:0]     rst_mid;
    logic [1:0]     start;
    logic [1:0]     busy, done, core_start, core_done;
    logic [WW-1:0]  src_base, dst_base;
    logic [N*DW-1:0] core_x [2];
    logic [N*DW-1:0] core_y [2];
    int             l_core, h_core;
    logic           force_done;
    logic           pre_we;
    logic [WW-1:0]  pre_addr;
    logic [DW-1:0]  pre_data;
    int             errors = 0;
    int             checks = 0;
    logic [DW-1:0]  ref_mem [DEPTH];

    for (genvar g = 0; g < 2; g++) begin : gi
        ntt_bram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

        ntt_bram_ctrl #(
            .N(N), .DATA_W(DW), .ADDR_W(AW), .BYTE_SHIFT(BS), .RD_LAT(g + 1)
        ) dut (
            .clk        (clk),
            .rst        (rst_all | rst_mid[g]),
            .start      (start[g]),
            .src_base   (src_base),
            .dst_base   (dst_base),
            .busy       (busy[g]),
            .done       (done[g]),
            .bram       (bif),
            .core_x     (core_x[g]),
            .core_start (core_start[g]),
            .core_done  (core_done[g]),
            .core_y     (core_y[g])
        );

        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_pipe [g + 1];
        int unsigned   rd_log [$];
        int            wr_cnt = 0;

        // BRAM with (g+1)-cycle read latency; the bench preload port has priority.
        always @(posedge clk) begin
            if (pre_we) begin
                mem[pre_addr] <= pre_data;
            end else if (bif.bram_en && bif.bram_we) begin
                mem[WW'(bif.bram_addr >> BS)] <= bif.bram_din;
                wr_cnt <= wr_cnt + 1;
            end
            if (bif.bram_en && !bif.bram_we) begin
                rd_log.push_back(int'(bif.bram_addr >> BS));
            end
            rd_pipe[0] <= mem[WW'(bif.bram_addr >> BS)];
            for (int i = 1; i <= g; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
        assign bif.bram_dout = rd_pipe[g];

        int            t = 0;
        logic [N*DW-1:0] y_m = '0;

        // Core model: y = x + 1, done after l_core cycles held for h_core; result is
        // corrupted after the first done cycle so a second snapshot would show.
        always @(posedge clk) begin
            if (core_start[g]) begin
                t <= 1;
                for (int k = 0; k < N; k++) begin
                    y_m[k*DW +: DW] <= core_x[g][k*DW +: DW] + 16'd1;
                end
            end else if (t != 0) begin
                if (t == l_core) begin
                    y_m <= ~y_m;
                end
                t <= (t >= l_core + h_core - 1) ? 0 : t + 1;
            end
        end
        assign core_done[g] = (t >= l_core && t < l_core + h_core) || force_done;
        assign core_y[g]    = y_m;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_of(input int g, input int a);
        if (g == 0) return gi[0].mem[a];
        else return gi[1].mem[a];
    endfunction

    function automatic int wrcnt(input int g);
        if (g == 0) return gi[0].wr_cnt;
        else return gi[1].wr_cnt;
    endfunction

    function automatic int rdlog_size(input int g);
        if (g == 0) return gi[0].rd_log.size();
        else return gi[1].rd_log.size();
    endfunction

    function automatic int rdlog_at(input int g, input int i);
        if (g == 0) return int'(gi[0].rd_log[i]);
        else return int'(gi[1].rd_log[i]);
    endfunction

    // {bram_rst, bram_en, bram_we, bram_addr, bram_din}
    function automatic logic [31:0] bus_of(input int g);
        if (g == 0) return {gi[0].bif.bram_rst, gi[0].bif.bram_en, gi[0].bif.bram_we,
                            gi[0].bif.bram_addr, gi[0].bif.bram_din};
        else return {gi[1].bif.bram_rst, gi[1].bif.bram_en, gi[1].bif.bram_we,
                     gi[1].bif.bram_addr, gi[1].bif.bram_din};
    endfunction

    task automatic preload(input int a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = WW'(a);
        pre_data = d;
        ref_mem[a % DEPTH] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Fill destination window (with neighbours) randomly, then the source window.
    task automatic prep(input int src, input int dst, input bit ramp);
        for (int a = -1; a <= N; a++) preload((dst + a + DEPTH) % DEPTH, DW'($urandom));
        for (int k = 0; k < N; k++) preload((src + k) % DEPTH, ramp ? DW'(k) : DW'($urandom));
    endtask

    // mode 0: plain job, 1: start/done handshake abuse, 2: reset after 3 writes
    task automatic run_job(input int src, input int dst, input int lc, input int hc,
                           input int mode, input string name);
        int base_rd [2];
        int base_wr [2];
        int done_cyc [2];
        int done_cnt [2];
        int busy_low [2];
        int busy_after [2];
        bit rst_seen [2];
        logic [DW-1:0] x_exp [N];
        int run_len;
        l_core = lc;
        h_core = hc;
        run_len = 2 * N + lc + hc + 12;
        for (int k = 0; k < N; k++) x_exp[k] = ref_mem[(src + k) % DEPTH];
        for (int g = 0; g < 2; g++) begin
            base_rd[g] = rdlog_size(g);
            base_wr[g] = wrcnt(g);
            done_cyc[g] = 0; done_cnt[g] = 0; busy_low[g] = 0; busy_after[g] = 0;
            rst_seen[g] = 1'b0;
        end
        src_base = WW'(src);
        dst_base = WW'(dst);
        start    = 2'b11;
        @(posedge clk);
        #1;
        start = 2'b00;
        for (int c = 1; c <= run_len; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                start = 2'b00;
                src_base = WW'(src);
                dst_base = WW'(dst);
                if (c == 3 || c == N + 4) begin
                    start = 2'b11;
                    src_base = WW'(src + 100);
                    dst_base = WW'(dst + 50);
                end
            end
            for (int g = 0; g < 2; g++) begin
                if (mode == 2) begin
                    if (rst_mid[g]) begin
                        check($sformatf("%s g%0d we after rst", name, g), bus_of(g)[29], 1'b0);
                        check($sformatf("%s g%0d busy after rst", name, g), busy[g], 1'b0);
                        rst_mid[g] = 1'b0;
                        rst_seen[g] = 1'b1;
                    end else if (!rst_seen[g] && bus_of(g)[29] && wrcnt(g) - base_wr[g] == 2) begin
                        rst_mid[g] = 1'b1;
                    end
                end
                if (done_cnt[g] == 0 && !busy[g] && mode != 2) busy_low[g]++;
                if (done_cnt[g] > 0 && !done[g] && busy[g]) busy_after[g]++;
                if (done[g]) begin
                    done_cnt[g]++;
                    if (done_cnt[g] == 1) done_cyc[g] = c;
                    if (mode == 1) start[g] = 1'b1;
                end
            end
        end
        start = 2'b00;
        for (int g = 0; g < 2; g++) begin
            if (mode == 2) begin
                check($sformatf("%s g%0d reset seen", name, g), rst_seen[g], 1'b1);
                check($sformatf("%s g%0d done count", name, g), done_cnt[g], 0);
                check($sformatf("%s g%0d writes", name, g), wrcnt(g) - base_wr[g], 3);
                for (int k = 0; k < N; k++)
                    check($sformatf("%s g%0d mem[%0d]", name, g, (dst + k) % DEPTH),
                          mem_of(g, (dst + k) % DEPTH),
                          (k < 3) ? DW'(x_exp[k] + 16'd1) : ref_mem[(dst + k) % DEPTH]);
            end else begin
                check($sformatf("%s g%0d done count", name, g), done_cnt[g], 1);
                check($sformatf("%s g%0d latency", name, g), done_cyc[g], 2 * N + (g + 1) + lc + 2);
                check($sformatf("%s g%0d busy gaps", name, g), busy_low[g], 0);
                check($sformatf("%s g%0d busy after done", name, g), busy_after[g], 0);
                check($sformatf("%s g%0d reads", name, g), rdlog_size(g) - base_rd[g], N);
                check($sformatf("%s g%0d writes", name, g), wrcnt(g) - base_wr[g], N);
                for (int k = 0; k < N; k++) begin
                    if (base_rd[g] + k < rdlog_size(g))
                        check($sformatf("%s g%0d rd addr %0d", name, g, k),
                              rdlog_at(g, base_rd[g] + k), (src + k) % DEPTH);
                    check($sformatf("%s g%0d core_x[%0d]", name, g, k),
                          core_x[g][k*DW +: DW], x_exp[k]);
                    check($sformatf("%s g%0d mem[%0d]", name, g, (dst + k) % DEPTH),
                          mem_of(g, (dst + k) % DEPTH), DW'(x_exp[k] + 16'd1));
                end
                check($sformatf("%s g%0d mem below", name, g),
                      mem_of(g, (dst + DEPTH - 1) % DEPTH), ref_mem[(dst + DEPTH - 1) % DEPTH]);
                check($sformatf("%s g%0d mem above", name, g),
                      mem_of(g, (dst + N) % DEPTH), ref_mem[(dst + N) % DEPTH]);
            end
        end
        for (int k = 0; k < N; k++)
            if (mode != 2 || k < 3) ref_mem[(dst + k) % DEPTH] = x_exp[k] + 16'd1;
    endtask

    initial begin
        int src, dst;
        rst_all = 1'b1; rst_mid = 2'b00; start = 2'b00; src_base = '0; dst_base = '0;
        force_done = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        l_core = 3; h_core = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset g%0d bus", g), bus_of(g), 32'h8000_0000);
            check($sformatf("reset g%0d busy/done/cstart", g), {busy[g], done[g], core_start[g]}, 3'b000);
            check($sformatf("reset g%0d core_x", g), core_x[g], '0);
        end
        @(posedge clk);
        #1;
        rst_all = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 2'b00);

        // Basic job with ramp data.
        prep(0, 8, 1'b1);
        run_job(0, 8, 3, 1, 0, "basic");

        // Source window wraps past the top of the word address space.
        src = DEPTH - 3;
        dst = int'($urandom_range(20, 1500));
        prep(src, dst, 1'b0);
        run_job(src, dst, 2, 2, 0, "wrap");

        // core_done in IDLE is ignored.
        @(posedge clk); #1;
        src = wrcnt(0);
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle core_done busy", busy, 2'b00);
            check("idle core_done done", done, 2'b00);
        end
        check("idle core_done writes", wrcnt(0), src);

        // Start pulses in LOAD, WAIT and FINISH; core_done held for 5 cycles.
        src = int'($urandom_range(0, 1000));
        dst = src + 500;
        prep(src, dst, 1'b0);
        run_job(src, dst, 3, 5, 1, "handshake");

        // Randomized jobs.
        for (int j = 0; j < 4; j++) begin
            src = int'($urandom_range(0, DEPTH - 1));
            dst = (src + 8 + int'($urandom_range(0, 2000))) % DEPTH;
            prep(src, dst, 1'b0);
            run_job(src, dst, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 0,
                    $sformatf("rand%0d", j));
        end

        // Reset after three writes, then a full job.
        prep(0, 8, 1'b1);
        run_job(0, 8, 3, 1, 2, "rst_store");
        run_job(0, 8, 3, 1, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
